// File: rtl/shift_arbiter.sv
// ============================================================================
// Module  : shift_arbiter (with its shifter datapath)
// Brief   : Round-robin front-end sharing one complex shifter between two
//           requesters over valid/ready request and response handshakes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef SLL
`define SLL 5'h08
`endif
`ifndef SRL
`define SRL 5'h09
`endif
`ifndef SRA
`define SRA 5'h0A
`endif
`ifndef ROL
`define ROL 5'h0B
`endif
`ifndef ROR
`define ROR 5'h0C
`endif

module shifter #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int SA_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] A_Re,
  input  logic [DATA_WIDTH-1:0] A_Im,
  input  logic [SA_WIDTH-1:0]   SA_Re,
  input  logic [SA_WIDTH-1:0]   SA_Im,
  input  logic [4:0]            Op,
  input  logic                  Mode,
  output logic [DATA_WIDTH-1:0] Res_Re,
  output logic [DATA_WIDTH-1:0] Res_Im
);

  logic [SA_WIDTH-1:0] w_saIm;

  // Rotates shift a doubled copy so the wrapped bits fall out of the window.
  function automatic logic [DATA_WIDTH-1:0] shiftOne(
    input logic [4:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [SA_WIDTH-1:0]   sa
  );
    logic [2*DATA_WIDTH-1:0] dbl;
    dbl      = {a, a};
    shiftOne = '0;
    case (op)
      `SLL: shiftOne = a << sa;
      `SRL: shiftOne = a >> sa;
      `SRA: shiftOne = $signed(a) >>> sa;
      `ROL: begin
        dbl      = dbl << sa;
        shiftOne = dbl[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      `ROR: begin
        dbl      = dbl >> sa;
        shiftOne = dbl[DATA_WIDTH-1:0];
      end
      default: shiftOne = '0;
    endcase
  endfunction

  // Complex mode applies the same rotation/scale to both parts.
  assign w_saIm = Mode ? SA_Re : SA_Im;
  assign Res_Re = shiftOne(Op, A_Re, SA_Re);
  assign Res_Im = shiftOne(Op, A_Im, w_saIm);

endmodule

module shift_arbiter #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int SA_WIDTH   = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req_a_re0,
  input  logic [DATA_WIDTH-1:0] req_a_re1,
  input  logic [DATA_WIDTH-1:0] req_a_im0,
  input  logic [DATA_WIDTH-1:0] req_a_im1,
  input  logic [SA_WIDTH-1:0]   req_sa_re0,
  input  logic [SA_WIDTH-1:0]   req_sa_re1,
  input  logic [SA_WIDTH-1:0]   req_sa_im0,
  input  logic [SA_WIDTH-1:0]   req_sa_im1,
  input  logic [4:0]            req_op0,
  input  logic [4:0]            req_op1,
  input  logic [1:0]            req_mode,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_re,
  output logic [DATA_WIDTH-1:0] rsp_im,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  logic [1:0]            r_state;
  logic                  r_lastGrant;
  logic                  r_gntId;
  logic [DATA_WIDTH-1:0] r_aRe;
  logic [DATA_WIDTH-1:0] r_aIm;
  logic [SA_WIDTH-1:0]   r_saRe;
  logic [SA_WIDTH-1:0]   r_saIm;
  logic [4:0]            r_op;
  logic                  r_mode;
  logic [DATA_WIDTH-1:0] r_rspRe;
  logic [DATA_WIDTH-1:0] r_rspIm;
  logic                  r_rspErr;

  logic                  w_gnt;
  logic                  w_accept;
  logic                  w_opLegal;
  logic [DATA_WIDTH-1:0] w_resRe;
  logic [DATA_WIDTH-1:0] w_resIm;

  // A tie goes to the requester that did not win last; a lone valid wins outright.
  assign w_gnt     = (req_valid == 2'b11) ? ~r_lastGrant : req_valid[1];
  assign w_accept  = (r_state == c_IDLE) && (|req_valid);
  assign req_ready = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

  assign w_opLegal = (r_op == `SLL) || (r_op == `SRL) || (r_op == `SRA) ||
                     (r_op == `ROL) || (r_op == `ROR);

  shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SA_WIDTH   (SA_WIDTH)
  ) u_shifter (
    .A_Re   (r_aRe),
    .A_Im   (r_aIm),
    .SA_Re  (r_saRe),
    .SA_Im  (r_saIm),
    .Op     (r_op),
    .Mode   (r_mode),
    .Res_Re (w_resRe),
    .Res_Im (w_resIm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_lastGrant <= 1'b1;
      r_gntId     <= 1'b0;
      r_aRe       <= '0;
      r_aIm       <= '0;
      r_saRe      <= '0;
      r_saIm      <= '0;
      r_op        <= '0;
      r_mode      <= 1'b0;
      r_rspRe     <= '0;
      r_rspIm     <= '0;
      r_rspErr    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_aRe       <= w_gnt ? req_a_re1  : req_a_re0;
            r_aIm       <= w_gnt ? req_a_im1  : req_a_im0;
            r_saRe      <= w_gnt ? req_sa_re1 : req_sa_re0;
            r_saIm      <= w_gnt ? req_sa_im1 : req_sa_im0;
            r_op        <= w_gnt ? req_op1    : req_op0;
            r_mode      <= req_mode[w_gnt];
            r_gntId     <= w_gnt;
            r_lastGrant <= w_gnt;
            r_state     <= c_EXEC;
          end
        end
        c_EXEC: begin
          r_rspRe  <= w_resRe;
          r_rspIm  <= w_resIm;
          r_rspErr <= ~w_opLegal;
          r_state  <= c_RESP;
        end
        c_RESP: begin
          if (rsp_ready[r_gntId]) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == c_RESP) ? (r_gntId ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (r_state != c_IDLE);
  assign rsp_re    = r_rspRe;
  assign rsp_im    = r_rspIm;
  assign rsp_err   = r_rspErr;

endmodule

`default_nettype wire
